// File: rtl/noise_pkg.sv
// noise_pkg: tap positions, default seed and FSM encoding shared by the noise generator
package noise_pkg;
    localparam int LONG_TAP_A = 30;
    localparam int LONG_TAP_B = 27;
    localparam int SHORT_TAP_A = 6;
    localparam int SHORT_TAP_B = 5;
    localparam logic [30:0] DEFAULT_SEED = 31'h1A92_6572;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
endpackage

// File: rtl/noise_lfsr.sv
// noise_lfsr: 31-bit Fibonacci LFSR with long/short feedback and short-loop zero escape
module noise_lfsr import noise_pkg::*; #(
    parameter logic [30:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [30:0] load_val,
    input  logic        mode,
    output logic        fb
);
    logic [30:0] s;
    // an all-zero 7-bit window after a mode switch would lock the short loop, so force a one
    always_comb fb = mode ? ((s[SHORT_TAP_A:0] == '0) ? 1'b1 : s[SHORT_TAP_A] ^ s[SHORT_TAP_B])
                          : s[LONG_TAP_A] ^ s[LONG_TAP_B];
    always_ff @(posedge clk) begin
        if (rst) s <= SEED;
        else if (load) s <= load_val;
        else if (step) s <= {s[29:0], fb};
    end
endmodule

// File: rtl/noise_gen.sv
// noise_gen: rate-divided pseudo-random sample source built from serial LFSR steps
module noise_gen import noise_pkg::*; #(
    parameter int          OUT_W = 8,
    parameter int          DIV_W = 16,
    parameter logic [30:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             short_mode,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    output logic [OUT_W-1:0] sout,
    output logic             sout_valid,
    output logic             overrun
);
    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [4:0]       step_cnt;
    logic [OUT_W-1:0] collect;
    logic             mode_q, fb, tick;
    assign tick = enable && cnt == '0;
    noise_lfsr #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (state == SHIFT),
        .load     (seed_load),
        .load_val ((seed == '0) ? SEED : seed),
        .mode     (mode_q),
        .fb       (fb)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step_cnt   <= '0;
            collect    <= '0;
            mode_q     <= 1'b0;
            sout       <= '0;
            sout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (seed_load) begin
            state      <= IDLE;
            cnt        <= rate_div;
            sout_valid <= 1'b0;
        end else begin
            sout_valid <= 1'b0;
            cnt        <= tick ? rate_div : enable ? cnt - DIV_W'(1) : cnt;
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    mode_q   <= short_mode;
                    step_cnt <= '0;
                    collect  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    collect  <= (collect << 1) | OUT_W'(fb);
                    step_cnt <= step_cnt + 5'd1;
                    state    <= (step_cnt == 5'(OUT_W - 1)) ? LOAD : SHIFT;
                end
                LOAD: begin
                    sout       <= collect;
                    sout_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noise_gen.sv
// tb_noise_gen: randomized checks of noise_gen against a bit-sequence recurrence model
module tb_noise_gen;
    import noise_pkg::*;
    localparam int OUT_W = 8;
    localparam int DIV_W = 16;
    localparam int MAXC  = 20000;
    logic             clk = 0, rst = 1, enable = 0, short_mode = 0, seed_load = 0;
    logic [DIV_W-1:0] rate_div = '0;
    logic [30:0]      seed = '0;
    logic [OUT_W-1:0] sout;
    logic             sout_valid, overrun;
    int cyc = 0, checks = 0, errors = 0, n = 0;
    bit rand_mode = 0;
    bit mode_at[MAXC];
    typedef struct {int c; logic [OUT_W-1:0] w;} ev_t;
    ev_t q[$];
    bit  hist[$];

    noise_gen #(.OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rate_div(rate_div),
        .short_mode(short_mode), .seed_load(seed_load), .seed(seed),
        .sout(sout), .sout_valid(sout_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (cyc + 1 < MAXC) mode_at[cyc + 1] = short_mode;
        cyc <= cyc + 1;
    end
    always @(negedge clk) if (sout_valid) q.push_back('{cyc, sout});

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output bit sequence b[n]: long b[n]=b[n-31]^b[n-28]; short b[n]=b[n-7]^b[n-6], or 1 after seven zeros
    function automatic void model_seed(input logic [30:0] s);
        hist = {};
        for (int i = 30; i >= 0; i--) hist.push_back(s[i]);
    endfunction

    function automatic logic [OUT_W-1:0] model_word(input bit m);
        logic [OUT_W-1:0] w = '0;
        bit b, zero;
        int k;
        for (int i = 0; i < OUT_W; i++) begin
            k = hist.size();
            zero = 1;
            for (int j = 1; j <= 7; j++) if (hist[k-j]) zero = 0;
            b = m ? (zero ? 1'b1 : hist[k-7] ^ hist[k-6]) : hist[k-31] ^ hist[k-28];
            hist.push_back(b);
            void'(hist.pop_front());
            w = (w << 1) | OUT_W'(b);
        end
        return w;
    endfunction

    task automatic cyc1();
        @(posedge clk);
        #1;
        if (rand_mode) short_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) cyc1();
    endtask

    task automatic do_seed(output int n0, input logic [30:0] sv, input int r, input bit sm);
        seed = sv;
        rate_div = DIV_W'(r);
        short_mode = sm;
        enable = 1;
        seed_load = 1;
        cyc1();
        seed_load = 0;
        n0 = cyc;
        q.delete();
    endtask

    task automatic wait_words(input int k, input int limit);
        while (q.size() < k && cyc < limit) cyc1();
        if (q.size() < k) check("timeout_words", 64'(q.size()), 64'(k));
    endtask

    task automatic verify(input int n0, input int r, input logic [30:0] sv, input int nw);
        int t;
        model_seed((sv == '0) ? DEFAULT_SEED : sv);
        for (int j = 0; j < nw && j < q.size(); j++) begin
            t = n0 + (r + 1) * (j + 1);
            check("word", 64'(q[j].w), 64'(model_word(mode_at[t])));
            check("valid_cycle", 64'(q[j].c), 64'(t + OUT_W + 1));
        end
    endtask

    initial begin
        int t1, n2;
        int r;
        logic [30:0] sv;
        logic [OUT_W-1:0] held;
        repeat (3) cyc1();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            cyc1();
            check("idle_outputs", 64'({sout, sout_valid, overrun}), 64'(0));
        end

        do_seed(n, 31'h1, 15, 1);
        wait_words(17, n + 400);
        if (q.size() > 0) check("short_first_word", 64'(q[0].w), 64'h06);
        verify(n, 15, 31'h1, 17);

        do_seed(n, 31'h0, 15, 0);
        wait_words(8, n + 250);
        verify(n, 15, 31'h0, 8);

        do_seed(n, 31'h4000_0000, 15, 1);
        wait_words(4, n + 150);
        if (q.size() > 0) check("escape_msb", 64'(q[0].w[OUT_W-1]), 64'(1));
        for (int j = 0; j < q.size(); j++) check("escape_nonzero", 64'(q[j].w != '0), 64'(1));
        verify(n, 15, 31'h4000_0000, 4);

        do_seed(n, 31'h5A5A_0F0F, 15, 0);
        t1 = n + 32;
        wait_until(t1 + 3);
        held = sout;
        check("abort_first_word_seen", 64'(q.size()), 64'(1));
        seed = 31'h0123_4567;
        seed_load = 1;
        cyc1();
        seed_load = 0;
        n2 = cyc;
        q.delete();
        wait_until(n2 + 24);
        check("abort_no_valid", 64'(q.size()), 64'(0));
        check("abort_sout_held", 64'(sout), 64'(held));
        wait_words(2, n2 + 80);
        verify(n2, 15, 31'h0123_4567, 2);

        rand_mode = 1;
        for (int it = 0; it < 6; it++) begin
            sv = 31'($urandom);
            if (it == 2) sv = '0;
            r = $urandom_range(OUT_W + 1, 20);
            do_seed(n, sv, r, 1'($urandom_range(0, 1)));
            wait_words(6, n + (r + 1) * 8 + 20);
            verify(n, r, sv, 6);
        end
        rand_mode = 0;

        do_seed(n, 31'h2A5A_1234, 0, 0);
        check("overrun_before", 64'(overrun), 64'(0));
        cyc1();
        check("overrun_first_tick", 64'(overrun), 64'(0));
        cyc1();
        check("overrun_second_tick", 64'(overrun), 64'(1));
        wait_words(3, n + 60);
        model_seed(31'h2A5A_1234);
        for (int j = 0; j < q.size() && j < 3; j++) begin
            t1 = n + 1 + j * (OUT_W + 2);
            check("fast_word", 64'(q[j].w), 64'(model_word(mode_at[t1])));
            check("fast_valid_cycle", 64'(q[j].c), 64'(t1 + OUT_W + 1));
        end
        rst = 1;
        cyc1();
        rst = 0;
        enable = 0;
        check("reset_clears", 64'({sout, sout_valid, overrun}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noise_gen.md
# noise_gen

Parametrised pseudo-random noise source for the synth voice path; successor to the fixed 8-bit, 8-LFSR noise block. A single 31-bit Fibonacci LFSR is stepped OUT_W times per sample to assemble each output word. Rate divider, seed load, and a selectable short-period ("metallic", 127-step) mode are included. Output is a held sample plus a one-cycle valid strobe, consumed by the mixer / envelope stage.

## Interface
- OUT_W, 8: bits per output sample (1..31)
- DIV_W, 16: width of sample-rate divider
- SEED, 31'h1A92_6572: reset seed and zero-seed substitute (must be non-zero)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  divider run; low freezes divider (in-flight word completes)
- rate_div  in  DIV_W  sample period minus one, in clk cycles
- short_mode  in  1  1 = 7-bit loop (period 127), 0 = 31-bit loop (period 2^31-1)
- seed_load  in  1  one-cycle strobe: load seed into LFSR
- seed  in  31  seed value
- sout  out  OUT_W  current noise sample, held between updates
- sout_valid  out  1  one-cycle pulse when sout updates
- overrun  out  1  sticky: a tick arrived while a word was in progress

## Operation
- Divider: down-counter `cnt`. tick = enable & (cnt==0). On tick, cnt <= rate_div; else if enable, cnt <= cnt-1; else hold.
- FSM states IDLE, SHIFT, LOAD.
  - IDLE: on tick, latch short_mode into mode_q, clear step counter and collect register; go to SHIFT.
  - SHIFT: one LFSR step per cycle for OUT_W cycles; go to LOAD after step OUT_W.
  - LOAD: sout <= collect, sout_valid <= 1; go to IDLE.
- LFSR step: s <= {s[29:0], fb}; collect <= {collect[OUT_W-2:0], fb}. The first generated bit lands in the sout MSB.
- fb in long mode (taps 31,28): s[30]^s[27].
- fb in short mode (taps 7,6): s[6]^s[5], except fb=1 when s[6:0]==0. This is lock-up escape after a mode switch.
- mode_q is constant for a whole word; a short_mode change applies from the next word.
- A tick in SHIFT or LOAD is dropped and sets overrun. Overrun is cleared only by rst.
- seed_load (any state, highest priority after rst):
  - s <= (seed==0) ? SEED : seed.
  - FSM -> IDLE, aborting the word with no valid pulse.
  - cnt <= rate_div.
  - sout is held.
- rst: s=SEED, cnt=0, FSM=IDLE, sout=0, sout_valid=0, overrun=0, mode_q=0.

## Timing
- Tick in cycle t → SHIFT steps in cycles t+1..t+OUT_W → LOAD at t+OUT_W+1. sout and sout_valid are visible after the t+OUT_W+1 edge. Latency is OUT_W+1 cycles.
- Sample period is rate_div+1 cycles. No overrun requires rate_div ≥ OUT_W+1. rate_div=0 with enable=1 ticks every cycle; only every (OUT_W+2)-th tick is accepted, and each dropped tick sets overrun.
- With enable high from the first cycle after rst, the first tick is in that cycle, since cnt resets to 0.
- A rate_div change takes effect at the next reload.
- enable falling mid-word does not stop SHIFT/LOAD.
- sout_valid is exactly one cycle, with at most one pulse per OUT_W+2 cycles.

## Structure
- Package noise_pkg:
  - tap constants LONG_TAP_A=30, LONG_TAP_B=27, SHORT_TAP_A=6, SHORT_TAP_B=5
  - default seed constant
  - FSM state enum {IDLE, SHIFT, LOAD}
- Sub-module noise_lfsr (clk, rst, step, load, load_val, mode, fb): holds the 31-bit register, the feedback mux and the zero-escape. noise_gen holds the divider, FSM, collect register and outputs.

## Test plan
- Reset, then hold enable=0 for 20 cycles → sout=0, sout_valid=0, overrun=0 throughout.
- OUT_W=8, rate_div=15, short_mode=1, seed_load with seed=31'h1, enable=1 → first sout=8'h06, valid exactly 9 cycles after tick. Over 127 consecutive steps the bitstream matches the x^7+x^6+1 model and repeats with period 127.
- Long mode, seed_load with seed=0 → LFSR equals SEED. The 8 words that follow match the software model of taps 31,28 seeded with SEED; valid pulses are 16 cycles apart.
- rate_div=0, enable=1 → valid every 10 cycles and overrun=1 from the second tick on; after rst, overrun=0.
- Long mode run to s[6:0]==0 (seed 31'h4000_0000), then set short_mode=1 → next word starts with fb=1; no lock-up, and nonzero words follow.
- seed_load asserted in the 4th SHIFT cycle → no valid pulse for that word, sout unchanged, next word begins rate_div+1 cycles later from the new seed.
